// File: rtl/pwm_capture.sv
`timescale 1ns/1ps
// pwm_capture: measures a synchronised half-bridge gate pair and emits one timing record per period.
// Define PWM_CAPTURE_GLITCH_FILTER_EN to add a filter_length-sample glitch filter on both channels.
module pwm_capture #(
    parameter int unsigned bitwidth      = 8,
    parameter int unsigned filter_length = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                highside_input,
    input  logic                lowside_input,
    input  logic                enable,
    output logic [bitwidth-1:0] tick_count_period,
    output logic [bitwidth-1:0] tick_count_highside,
    output logic [bitwidth-1:0] deadtime_hs_to_ls,
    output logic [bitwidth-1:0] tick_count_lowside,
    output logic [bitwidth-1:0] deadtime_ls_to_hs,
    output logic                capture_valid,
    output logic                overlap_error,
    output logic                timeout_error
);

    localparam int unsigned SumW = bitwidth + 2;
    localparam logic [bitwidth-1:0] CountMax = {bitwidth{1'b1}};

    typedef enum logic [2:0] {StIdle, StHsOn, StDtHs, StLsOn, StDtLs} state_e;

    if (filter_length < 1 || filter_length > 15) begin : g_filter_length_check
        $error("pwm_capture: filter_length must be in 1..15");
    end

    logic hs_meta, hs_sync, ls_meta, ls_sync;
    logic hs_lvl, ls_lvl, hs_prev, ls_prev;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hs_meta <= 1'b0;
            hs_sync <= 1'b0;
            ls_meta <= 1'b0;
            ls_sync <= 1'b0;
        end else begin
            hs_meta <= highside_input;
            hs_sync <= hs_meta;
            ls_meta <= lowside_input;
            ls_sync <= ls_meta;
        end
    end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    // Each filtered level flips only after filter_length consecutive differing samples.
    logic       hs_filt, ls_filt;
    logic [3:0] hs_run, ls_run;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hs_filt <= 1'b0;
            ls_filt <= 1'b0;
            hs_run  <= '0;
            ls_run  <= '0;
        end else begin
            if (hs_sync == hs_filt) begin
                hs_run <= '0;
            end else if (hs_run == 4'(filter_length - 1)) begin
                hs_filt <= hs_sync;
                hs_run  <= '0;
            end else begin
                hs_run <= hs_run + 4'd1;
            end
            if (ls_sync == ls_filt) begin
                ls_run <= '0;
            end else if (ls_run == 4'(filter_length - 1)) begin
                ls_filt <= ls_sync;
                ls_run  <= '0;
            end else begin
                ls_run <= ls_run + 4'd1;
            end
        end
    end

    assign hs_lvl = hs_filt;
    assign ls_lvl = ls_filt;
`else
    assign hs_lvl = hs_sync;
    assign ls_lvl = ls_sync;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hs_prev <= 1'b0;
            ls_prev <= 1'b0;
        end else begin
            hs_prev <= hs_lvl;
            ls_prev <= ls_lvl;
        end
    end

    logic hs_rise, hs_fall, ls_rise, ls_fall, overlap, timeout;
    state_e state_q, state_d;
    logic [bitwidth-1:0] seg_cnt_q, seg_cnt_d;

    assign hs_rise = hs_lvl & ~hs_prev;
    assign hs_fall = ~hs_lvl & hs_prev;
    assign ls_rise = ls_lvl & ~ls_prev;
    assign ls_fall = ~ls_lvl & ls_prev;
    assign overlap = hs_lvl & ls_lvl;
    assign timeout = (state_q != StIdle) && (seg_cnt_q == CountMax);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!enable || overlap || timeout) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: if (hs_rise) state_d = StHsOn;
                StHsOn: begin
                    // A lowside rise in the same clock as the highside fall is a zero deadtime.
                    if (hs_fall)      state_d = ls_rise ? StLsOn : StDtHs;
                    else if (ls_rise) state_d = StIdle;
                end
                StDtHs: begin
                    if (hs_rise)      state_d = StIdle;
                    else if (ls_rise) state_d = StLsOn;
                end
                StLsOn: begin
                    if (ls_fall)      state_d = hs_rise ? StHsOn : StDtLs;
                    else if (hs_rise) state_d = StIdle;
                end
                StDtLs: begin
                    if (ls_rise)      state_d = StIdle;
                    else if (hs_rise) state_d = StHsOn;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    logic store_hs, store_dt_hs, store_ls, commit;
    logic [bitwidth-1:0] hs_time_q, dt_hs_q, ls_time_q;
    logic [bitwidth-1:0] dt_hs_val, ls_val, dt_ls_val, period_val;
    logic [SumW-1:0]     period_sum;

    always_comb begin
        store_hs    = (state_q == StHsOn) && (state_d inside {StDtHs, StLsOn});
        store_dt_hs = (state_d == StLsOn) && (state_q inside {StHsOn, StDtHs});
        store_ls    = (state_q == StLsOn) && (state_d inside {StDtLs, StHsOn});
        commit      = (state_d == StHsOn) && (state_q inside {StLsOn, StDtLs});

        if (state_d == StIdle)        seg_cnt_d = '0;
        else if (state_d != state_q)  seg_cnt_d = {{(bitwidth-1){1'b0}}, 1'b1};
        else                          seg_cnt_d = seg_cnt_q + 1'b1;

        dt_hs_val  = (state_q == StHsOn) ? '0 : seg_cnt_q;
        ls_val     = (state_q == StLsOn) ? seg_cnt_q : ls_time_q;
        dt_ls_val  = (state_q == StLsOn) ? '0 : seg_cnt_q;
        period_sum = SumW'(hs_time_q) + SumW'(dt_hs_q) + SumW'(ls_val) + SumW'(dt_ls_val);
        period_val = (period_sum > SumW'(CountMax)) ? CountMax : period_sum[bitwidth-1:0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            seg_cnt_q           <= '0;
            hs_time_q           <= '0;
            dt_hs_q             <= '0;
            ls_time_q           <= '0;
            tick_count_period   <= '0;
            tick_count_highside <= '0;
            deadtime_hs_to_ls   <= '0;
            tick_count_lowside  <= '0;
            deadtime_ls_to_hs   <= '0;
            capture_valid       <= 1'b0;
            overlap_error       <= 1'b0;
            timeout_error       <= 1'b0;
        end else begin
            seg_cnt_q     <= seg_cnt_d;
            capture_valid <= commit;
            if (store_hs)    hs_time_q <= seg_cnt_q;
            if (store_dt_hs) dt_hs_q   <= dt_hs_val;
            if (store_ls)    ls_time_q <= seg_cnt_q;
            if (commit) begin
                tick_count_period   <= period_val;
                tick_count_highside <= hs_time_q;
                deadtime_hs_to_ls   <= dt_hs_q;
                tick_count_lowside  <= ls_val;
                deadtime_ls_to_hs   <= dt_ls_val;
            end
            if (!enable) begin
                overlap_error <= 1'b0;
                timeout_error <= 1'b0;
            end else begin
                overlap_error <= overlap_error | overlap;
                timeout_error <= timeout_error | (timeout & ~overlap);
            end
        end
    end

endmodule
